// File: rtl/seg_scan_display.sv
// 4-digit multiplexed 7-segment scanner with frame-synchronous snapshot,
// inter-digit blank gap, leading-zero blanking and out-of-range blinking dashes.
//
// state | meaning
// BLANK | all digits off (anti-ghosting gap before the next ON slot)
// ON    | digit idx is driven for SCAN_DIV cycles
module seg_scan_display #(
    parameter int         SCAN_DIV     = 50000,
    parameter int         BLANK_CYC    = 500,
    parameter int         BLINK_FRAMES = 125,
    parameter logic [6:0] ZERO_CODE    = 7'h3F,
    parameter logic [6:0] DASH_CODE    = 7'h40
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [6:0] th,
    input  logic [6:0] hundred,
    input  logic [6:0] ten,
    input  logic [6:0] one,
    input  logic       out_range,
    output logic [6:0] seg,
    output logic [3:0] dig_en,
    output logic       frame_tick
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t           state, state_n;
    logic [1:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             snap, frame_end;

    logic [6:0]       th_s, hu_s, te_s, on_s;
    logic             or_s;
    logic [6:0]       th_n, hu_n, te_n, on_n;
    logic             or_n;
    logic [BLK_W-1:0] blink_cnt, blink_cnt_n;
    logic             blink_phase, blink_phase_n;

    logic [6:0]       seg_n;
    logic [3:0]       dig_n;
    logic             tick_n;
    logic             blank_th, blank_hu, blank_te;

    // Slot sequencing: BLANK gap then ON slot, advancing idx after each ON slot.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt + CNT_W'(1);
        snap      = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = ST_ON;
                    cnt_n   = '0;
                    snap    = (idx == 2'd0);
                end
            end
            default: begin
                if (cnt == SCAN_LAST) begin
                    state_n   = ST_BLANK;
                    cnt_n     = '0;
                    idx_n     = idx + 2'd1;
                    frame_end = (idx == 2'd3);
                end
            end
        endcase
    end

    // Snapshot at frame start; blink counter advances once per out-of-range frame.
    always_comb begin
        th_n          = th_s;
        hu_n          = hu_s;
        te_n          = te_s;
        on_n          = on_s;
        or_n          = or_s;
        blink_cnt_n   = blink_cnt;
        blink_phase_n = blink_phase;
        if (snap) begin
            th_n = th;
            hu_n = hundred;
            te_n = ten;
            on_n = one;
            or_n = out_range;
            if (!out_range) begin
                blink_cnt_n   = '0;
                blink_phase_n = 1'b0;
            end
        end else if (frame_end && or_s) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n   = '0;
                blink_phase_n = ~blink_phase;
            end else begin
                blink_cnt_n = blink_cnt + BLK_W'(1);
            end
        end
    end

    // Output decode from next-state values so outputs switch on the same edge as the FSM.
    always_comb begin
        blank_th = (th_n == ZERO_CODE);
        blank_hu = blank_th && (hu_n == ZERO_CODE);
        blank_te = blank_hu && (te_n == ZERO_CODE);
        seg_n    = 7'h00;
        dig_n    = 4'b1111;
        tick_n   = (state_n == ST_ON) && (idx_n == 2'd3) && (cnt_n == SCAN_LAST);
        if (state_n == ST_ON) begin
            if (or_n) begin
                if (!blink_phase_n) begin
                    seg_n = DASH_CODE;
                    dig_n = ~(4'b0001 << idx_n);
                end
            end else begin
                case (idx_n)
                    2'd0: begin
                        seg_n = on_n;
                        dig_n = 4'b1110;
                    end
                    2'd1: if (!blank_te) begin
                        seg_n = te_n;
                        dig_n = 4'b1101;
                    end
                    2'd2: if (!blank_hu) begin
                        seg_n = hu_n;
                        dig_n = 4'b1011;
                    end
                    default: if (!blank_th) begin
                        seg_n = th_n;
                        dig_n = 4'b0111;
                    end
                endcase
            end
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_BLANK;
            idx         <= 2'd0;
            cnt         <= '0;
            th_s        <= 7'h00;
            hu_s        <= 7'h00;
            te_s        <= 7'h00;
            on_s        <= 7'h00;
            or_s        <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= 7'h00;
            dig_en      <= 4'b1111;
            frame_tick  <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            th_s        <= th_n;
            hu_s        <= hu_n;
            te_s        <= te_n;
            on_s        <= on_n;
            or_s        <= or_n;
            blink_cnt   <= blink_cnt_n;
            blink_phase <= blink_phase_n;
            seg         <= seg_n;
            dig_en      <= dig_n;
            frame_tick  <= tick_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with small scan parameters.
module tb_seg_scan_display;

    localparam int SCAN = 8;
    localparam int BLNK = 2;
    localparam int SLOT = SCAN + BLNK;
    localparam int FRM  = 4 * SLOT;

    localparam logic [6:0] C0 = 7'h3F, C1 = 7'h06, C2 = 7'h5B, C3 = 7'h4F, C4 = 7'h66;
    localparam logic [6:0] C5 = 7'h6D, C6 = 7'h7D, C7 = 7'h07, C8 = 7'h7F;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [6:0] th = 7'h00, hundred = 7'h00, ten = 7'h00, one = 7'h00;
    logic       out_range = 1'b0;
    logic [6:0] seg;
    logic [3:0] dig_en;
    logic       frame_tick;

    int vectors = 0;
    int miscompares = 0;

    // {dig_en, seg, frame_tick}
    logic [11:0] sb_q[$];

    seg_scan_display #(
        .SCAN_DIV(SCAN), .BLANK_CYC(BLNK), .BLINK_FRAMES(2),
        .ZERO_CODE(7'h3F), .DASH_CODE(7'h40)
    ) dut (
        .sys_clk(sys_clk), .reset(reset),
        .th(th), .hundred(hundred), .ten(ten), .one(one),
        .out_range(out_range),
        .seg(seg), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic set_digits(input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0, input logic oor);
        th = d3; hundred = d2; ten = d1; one = d0; out_range = oor;
    endtask

    // Expected 40-cycle frame: cycles 0-1 of each slot blank, then lit.
    task automatic push_frame(input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0,
                              input logic oor, input logic dark);
        logic [6:0] code [4];
        logic       hide [4];
        logic       lead;
        code[0] = d0; code[1] = d1; code[2] = d2; code[3] = d3;
        lead = 1'b1;
        hide[0] = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            if (lead && code[k] == C0) hide[k] = 1'b1;
            else begin
                hide[k] = 1'b0;
                lead = 1'b0;
            end
        end
        for (int i = 0; i < FRM; i++) begin
            int         slot;
            logic [3:0] de;
            logic [6:0] sg;
            slot = i / SLOT;
            de = 4'b1111;
            sg = 7'h00;
            if ((i % SLOT) >= BLNK) begin
                if (oor) begin
                    if (!dark) begin
                        de = 4'b1111;
                        de[slot] = 1'b0;
                        sg = 7'h40;
                    end
                end else if (!hide[slot]) begin
                    de = 4'b1111;
                    de[slot] = 1'b0;
                    sg = code[slot];
                end
            end
            sb_q.push_back({de, sg, (i == FRM - 1)});
        end
    endtask

    task automatic check_cycles(input int n, input string name);
        for (int c = 0; c < n; c++) begin
            logic [11:0] exp;
            @(negedge sys_clk);
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s: scoreboard empty at cycle %0d, got dig_en=%b seg=%h tick=%b",
                         name, c, dig_en, seg, frame_tick);
            end else begin
                exp = sb_q.pop_front();
                if ({dig_en, seg, frame_tick} !== exp) begin
                    miscompares++;
                    $display("FAIL %s: cycle %0d got dig_en=%b seg=%h tick=%b, expected dig_en=%b seg=%h tick=%b",
                             name, c, dig_en, seg, frame_tick, exp[11:8], exp[7:1], exp[0]);
                end
            end
        end
    endtask

    task automatic release_reset();
        @(posedge sys_clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        set_digits(C1, C2, C3, C4, 1'b0);
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (dig_en !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_dig_en: got %b expected 1111", dig_en);
        end
        vectors++;
        if (seg !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_seg: got %h expected 00", seg);
        end
        vectors++;
        if (frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tick: got %b expected 0", frame_tick);
        end
    endtask

    task automatic test_normal_1234();
        release_reset();
        push_frame(C1, C2, C3, C4, 1'b0, 1'b0);
        check_cycles(FRM, "normal_1234");
    endtask

    task automatic test_back_to_back();
        set_digits(C1, C2, C3, C4, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b0, 1'b0);
        check_cycles(FRM, "back_to_back");
    endtask

    task automatic test_leading_zero();
        set_digits(C0, C0, C1, C0, 1'b0);
        push_frame(C0, C0, C1, C0, 1'b0, 1'b0);
        check_cycles(FRM, "lead_0010");
        set_digits(C0, C0, C0, C0, 1'b0);
        push_frame(C0, C0, C0, C0, 1'b0, 1'b0);
        check_cycles(FRM, "lead_0000");
        set_digits(C0, C2, C0, C0, 1'b0);
        push_frame(C0, C2, C0, C0, 1'b0, 1'b0);
        check_cycles(FRM, "lead_0200");
    endtask

    task automatic test_out_range();
        set_digits(C1, C2, C3, C4, 1'b1);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b1);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b1);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b0);
        check_cycles(5 * FRM, "oor_blink");
        set_digits(C1, C2, C3, C4, 1'b1);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b1);
        check_cycles(2 * FRM, "oor_to_dark");
        set_digits(C0, C0, C7, C8, 1'b0);
        push_frame(C0, C0, C7, C8, 1'b0, 1'b0);
        check_cycles(FRM, "oor_exit");
        set_digits(C1, C2, C3, C4, 1'b1);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b1, 1'b1);
        check_cycles(3 * FRM, "oor_reenter");
        set_digits(C1, C2, C3, C4, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b0, 1'b0);
        check_cycles(FRM, "oor_exit2");
    endtask

    task automatic test_mid_frame_change();
        set_digits(C1, C2, C3, C4, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b0, 1'b0);
        push_frame(C5, C6, C7, C8, 1'b0, 1'b0);
        check_cycles(15, "mid_frame_head");
        set_digits(C5, C6, C7, C8, 1'b0);
        check_cycles(FRM - 15 + FRM, "mid_frame_tail");
    endtask

    task automatic test_reset_mid_slot();
        set_digits(C1, C2, C3, C4, 1'b0);
        push_frame(C1, C2, C3, C4, 1'b0, 1'b0);
        check_cycles(25, "pre_reset");
        sb_q.delete();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (dig_en !== 4'b1111 || seg !== 7'h00) begin
            miscompares++;
            $display("FAIL async_reset: got dig_en=%b seg=%h expected 1111/00", dig_en, seg);
        end
        release_reset();
        push_frame(C1, C2, C3, C4, 1'b0, 1'b0);
        check_cycles(FRM, "after_reset");
    endtask

    initial begin
        test_reset();
        test_normal_1234();
        test_back_to_back();
        test_leading_zero();
        test_out_range();
        test_mid_frame_change();
        test_reset_mid_slot();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
